// File: rtl/riscv_config_pkg.sv
// ---------------------------------------------------------------------------
// riscv_config_pkg
// Core-wide configuration constants shared by the pipeline blocks.
//   XLEN        : architectural register/data width
//   REG_ADDR_W  : register file address width
//   NUM_WB_REQ  : number of write-back requesters (0 = ALU, 1 = load,
//                 2 = mul/div)
// ---------------------------------------------------------------------------
package riscv_config_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_WB_REQ = 3;

endpackage : riscv_config_pkg

// File: rtl/riscv_core_pkg.sv
// ---------------------------------------------------------------------------
// riscv_core_pkg
// Core-wide types built on riscv_config_pkg.
//   reg_addr_t : register file address
//   word_t     : XLEN-wide data word
//   wb_req_t   : one write-back request (destination register + data)
// ---------------------------------------------------------------------------
package riscv_core_pkg;

   import riscv_config_pkg::*;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [XLEN-1:0]       word_t;

   typedef struct packed {
      reg_addr_t rd;
      word_t     data;
   } wb_req_t;

endpackage : riscv_core_pkg

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational one-hot grant generator. The search for a winner
// starts at i_ptr and wraps around; with i_ptr tied to zero it degenerates
// into a lowest-index-wins fixed priority arbiter.
// Ports:
//   i_req   [NUM_REQ-1:0] : request vector
//   i_ptr   [PTR_W-1:0]   : index where the search starts
//   o_grant [NUM_REQ-1:0] : one-hot grant, zero when no request
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PTR_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_grant
);

   logic [NUM_REQ-1:0] w_mask;
   logic [NUM_REQ-1:0] w_maskedReq;
   logic [NUM_REQ-1:0] w_maskedGrant;
   logic [NUM_REQ-1:0] w_plainGrant;

   // Mask keeps only requesters at or above the pointer, i.e. the part of
   // the circular search that comes before the wrap-around.
   for (genvar j = 0; j < NUM_REQ; j++) begin : g_mask
      assign w_mask[j] = (PTR_W'(j) >= i_ptr);
   end

   // x & -x isolates the lowest set bit. If any request sits at or above
   // the pointer the lowest of those wins; otherwise the search has wrapped
   // and the lowest request overall wins.
   assign w_maskedReq   = i_req & w_mask;
   assign w_maskedGrant = w_maskedReq & (-w_maskedReq);
   assign w_plainGrant  = i_req & (-i_req);

   assign o_grant = (|w_maskedReq) ? w_maskedGrant : w_plainGrant;

endmodule : rr_arbiter

// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
// Arbitrates the single register file write port between several
// write-back requesters. At most one request is accepted per cycle; the
// accepted address/data are registered and presented to the register file
// one cycle later. Writes to x0 are accepted but never issued.
//
// Build option:
//   WB_ARB_ROUND_ROBIN_EN defined   : round-robin grant, pointer moves to
//                                     winner+1 on every transfer
//   WB_ARB_ROUND_ROBIN_EN undefined : fixed priority, lowest index wins
//
// Ports:
//   clk_i, rst_i       : clock, synchronous active-high reset
//   flush_i            : drop this cycle's arbitration and the staged write
//   req_valid_i        : per-requester request valid
//   req_ready_o        : per-requester acceptance (one-hot or zero)
//   req_rd_addr_i      : per-requester destination register
//   req_rd_data_i      : per-requester write data
//   rf_write_en_o      : register file write enable
//   rf_rd_addr_o       : register file write address
//   rf_rd_data_o       : register file write data
//   conflict_cnt_o     : saturating count of contended cycles
// ---------------------------------------------------------------------------
module wb_port_arbiter
   import riscv_config_pkg::*;
#(
   parameter int NUM_REQ        = NUM_WB_REQ,
   parameter int DATA_WIDTH     = XLEN,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                                    clk_i,
   input  logic                                    rst_i,
   input  logic                                    flush_i,
   input  logic [NUM_REQ-1:0]                      req_valid_i,
   output logic [NUM_REQ-1:0]                      req_ready_o,
   input  logic [NUM_REQ-1:0][REG_ADDR_WIDTH-1:0]  req_rd_addr_i,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]      req_rd_data_i,
   output logic                                    rf_write_en_o,
   output logic [REG_ADDR_WIDTH-1:0]               rf_rd_addr_o,
   output logic [DATA_WIDTH-1:0]                   rf_rd_data_o,
   output logic [15:0]                             conflict_cnt_o
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]        w_grant;
   logic [PTR_W-1:0]          w_ptr;
   logic                      w_transfer;
   logic                      w_contended;
   logic [REG_ADDR_WIDTH-1:0] w_selAddr;
   logic [DATA_WIDTH-1:0]     w_selData;
   logic [REG_ADDR_WIDTH-1:0] w_addrChain [NUM_REQ+1];
   logic [DATA_WIDTH-1:0]     w_dataChain [NUM_REQ+1];

   logic                      r_wrEn;
   logic [REG_ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0]     r_data;
   logic [15:0]               r_conflictCnt;

`ifdef WB_ARB_ROUND_ROBIN_EN
   logic [PTR_W-1:0] r_ptr;
   logic [PTR_W-1:0] w_winIdx;
   logic [PTR_W-1:0] w_idxChain [NUM_REQ+1];

   assign w_ptr = r_ptr;
`else
   assign w_ptr = '0;
`endif

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_arbiter (
      .i_req   (req_valid_i),
      .i_ptr   (w_ptr),
      .o_grant (w_grant)
   );

   // Reset and flush both suppress acceptance outright, so a request
   // pending in those cycles is simply not taken and no write follows.
   assign req_ready_o = (rst_i || flush_i) ? '0 : w_grant;
   assign w_transfer  = |req_ready_o;

   // Two or more valid bits: clearing the lowest set bit leaves something.
   assign w_contended = |(req_valid_i & (req_valid_i - NUM_REQ'(1)));

   // AND-OR mux of the winning requester's address and data. Ready is
   // one-hot or zero, so at most one term contributes.
   assign w_addrChain[0] = '0;
   assign w_dataChain[0] = '0;
   for (genvar k = 0; k < NUM_REQ; k++) begin : g_sel
      assign w_addrChain[k+1] = w_addrChain[k]
                              | (req_rd_addr_i[k] & {REG_ADDR_WIDTH{req_ready_o[k]}});
      assign w_dataChain[k+1] = w_dataChain[k]
                              | (req_rd_data_i[k] & {DATA_WIDTH{req_ready_o[k]}});
   end
   assign w_selAddr = w_addrChain[NUM_REQ];
   assign w_selData = w_dataChain[NUM_REQ];

   // Staging register between arbitration and the register file port.
   // The enable only follows a real transfer to a non-zero register, and
   // flush kills whatever would have been staged. Address/data hold their
   // old value whenever nothing new is accepted.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wrEn <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
      end else if (flush_i) begin
         r_wrEn <= 1'b0;
      end else begin
         r_wrEn <= w_transfer && (w_selAddr != '0);
         if (w_transfer) begin
            r_addr <= w_selAddr;
            r_data <= w_selData;
         end
      end
   end

   // Contention counter: counts cycles with more than one valid request,
   // ignoring flushed cycles, and sticks at all-ones.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_conflictCnt <= '0;
      end else if (!flush_i && w_contended && (r_conflictCnt != 16'hFFFF)) begin
         r_conflictCnt <= r_conflictCnt + 16'd1;
      end
   end

`ifdef WB_ARB_ROUND_ROBIN_EN
   // Encode the one-hot winner into an index for the pointer update.
   assign w_idxChain[0] = '0;
   for (genvar k = 0; k < NUM_REQ; k++) begin : g_idx
      assign w_idxChain[k+1] = w_idxChain[k] | (req_ready_o[k] ? PTR_W'(k) : '0);
   end
   assign w_winIdx = w_idxChain[NUM_REQ];

   // Round-robin pointer: after a transfer the search starts just past the
   // winner, wrapping to zero after the last requester. Without a transfer
   // (idle, flush) it stays where it is.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ptr <= '0;
      end else if (w_transfer) begin
         r_ptr <= (w_winIdx == PTR_W'(NUM_REQ - 1)) ? '0 : w_winIdx + PTR_W'(1);
      end
   end
`endif

   assign rf_write_en_o  = r_wrEn;
   assign rf_rd_addr_o   = r_addr;
   assign rf_rd_data_o   = r_data;
   assign conflict_cnt_o = r_conflictCnt;

endmodule : wb_port_arbiter

// File: tb/tb_wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_port_arbiter
// Directed self-checking bench for wb_port_arbiter (default 3 requesters,
// 32-bit data, 5-bit register address). Inputs change 1 ns after each
// rising edge; outputs are checked in the same window after settling.
// Contention expectations follow WB_ARB_ROUND_ROBIN_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_wb_port_arbiter;

   import riscv_core_pkg::*;

   logic             clk_i;
   logic             rst_i;
   logic             flush_i;
   logic [2:0]       reqValid;
   logic [2:0]       req_ready_o;
   logic [2:0][4:0]  reqAddr;
   logic [2:0][31:0] reqData;
   logic             rf_write_en_o;
   logic [4:0]       rf_rd_addr_o;
   logic [31:0]      rf_rd_data_o;
   logic [15:0]      conflict_cnt_o;

   wb_req_t reqs [3];

   int passCount  = 0;
   int checkCount = 0;

   assign reqAddr = {reqs[2].rd,   reqs[1].rd,   reqs[0].rd};
   assign reqData = {reqs[2].data, reqs[1].data, reqs[0].data};

   wb_port_arbiter dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .flush_i        (flush_i),
      .req_valid_i    (reqValid),
      .req_ready_o    (req_ready_o),
      .req_rd_addr_i  (reqAddr),
      .req_rd_data_i  (reqData),
      .rf_write_en_o  (rf_write_en_o),
      .rf_rd_addr_o   (rf_rd_addr_o),
      .rf_rd_data_o   (rf_rd_data_o),
      .conflict_cnt_o (conflict_cnt_o)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Requester protocol assertion: a request that was valid but not
   // accepted must come back unchanged next cycle, unless reset or flush
   // dropped it. Sampled mid-cycle, where inputs and ready are settled.
   logic [2:0] prevValid;
   logic [2:0] prevReady;
   logic       prevDrop;
   logic       havePrev = 1'b0;
   wb_req_t    prevReq [3];

   always @(negedge clk_i) begin
      if (havePrev) begin
         for (int k = 0; k < 3; k++) begin
            if (prevValid[k] && !prevReady[k] && !prevDrop) begin
               assert (reqValid[k] && (reqs[k] == prevReq[k]))
                  else $error("[TB] FAIL hold_stable req%0d: valid=%b rd=%0d data=%h, required held rd=%0d data=%h",
                              k, reqValid[k], reqs[k].rd, reqs[k].data, prevReq[k].rd, prevReq[k].data);
            end
         end
      end
      prevValid = reqValid;
      prevReady = req_ready_o;
      prevDrop  = rst_i || flush_i;
      for (int k = 0; k < 3; k++) prevReq[k] = reqs[k];
      havePrev  = 1'b1;
   end

   // Stimulus helpers.
   task automatic applyStimulus(input int k, input logic v, input logic [4:0] rd, input logic [31:0] d);
      reqValid[k]  = v;
      reqs[k].rd   = rd;
      reqs[k].data = d;
   endtask

   task automatic idleAll();
      for (int k = 0; k < 3; k++) applyStimulus(k, 1'b0, 5'd0, 32'd0);
   endtask

   task automatic nextCycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic doReset();
      rst_i   = 1'b1;
      flush_i = 1'b0;
      idleAll();
      nextCycle();
      nextCycle();
      rst_i = 1'b0;
   endtask

   // Reset held with every requester valid: nothing accepted, all clear.
   task automatic test_reset();
      rst_i   = 1'b1;
      flush_i = 1'b0;
      applyStimulus(0, 1'b1, 5'd1, 32'h1111_1111);
      applyStimulus(1, 1'b1, 5'd2, 32'h2222_2222);
      applyStimulus(2, 1'b1, 5'd3, 32'h3333_3333);
      #1;
      checkCount++;
      if (req_ready_o !== 3'b000) $display("[TB] FAIL reset_ready0: got %b required 000", req_ready_o);
      else passCount++;
      for (int c = 0; c < 2; c++) begin
         nextCycle();
         checkCount++;
         if (req_ready_o !== 3'b000) $display("[TB] FAIL reset_ready: got %b required 000", req_ready_o);
         else passCount++;
         checkCount++;
         if (rf_write_en_o !== 1'b0) $display("[TB] FAIL reset_wen: got %b required 0", rf_write_en_o);
         else passCount++;
         checkCount++;
         if (conflict_cnt_o !== 16'd0) $display("[TB] FAIL reset_cnt: got %h required 0000", conflict_cnt_o);
         else passCount++;
         checkCount++;
         if ({rf_rd_addr_o, rf_rd_data_o} !== 37'd0) $display("[TB] FAIL reset_addr_data: got %0d/%h required 0/0", rf_rd_addr_o, rf_rd_data_o);
         else passCount++;
      end
      rst_i = 1'b0;
      idleAll();
      nextCycle();
      checkCount++;
      if (rf_write_en_o !== 1'b0) $display("[TB] FAIL reset_dropped_write: got %b required 0", rf_write_en_o);
      else passCount++;
   endtask

   // Single uncontended request, latency-1 write, then hold.
   task automatic test_single();
      applyStimulus(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
      #1;
      checkCount++;
      if (req_ready_o !== 3'b010) $display("[TB] FAIL single_ready: got %b required 010", req_ready_o);
      else passCount++;
      nextCycle();
      idleAll();
      #1;
      checkCount++;
      if ({rf_write_en_o, rf_rd_addr_o, rf_rd_data_o} !== {1'b1, 5'd5, 32'hDEAD_BEEF})
         $display("[TB] FAIL single_write: got en=%b addr=%0d data=%h required en=1 addr=5 data=deadbeef",
                  rf_write_en_o, rf_rd_addr_o, rf_rd_data_o);
      else passCount++;
      nextCycle();
      checkCount++;
      if ({rf_write_en_o, rf_rd_addr_o, rf_rd_data_o} !== {1'b0, 5'd5, 32'hDEAD_BEEF})
         $display("[TB] FAIL single_hold: got en=%b addr=%0d data=%h required en=0 addr=5 data=deadbeef",
                  rf_write_en_o, rf_rd_addr_o, rf_rd_data_o);
      else passCount++;
   endtask

   // All three requesters valid for three cycles, then a flushed cycle.
   task automatic test_contention();
      logic [2:0] expGrant;
      logic [4:0] expAddr;
      doReset();
      applyStimulus(0, 1'b1, 5'd1, 32'hA000_0000);
      applyStimulus(1, 1'b1, 5'd2, 32'hA000_0001);
      applyStimulus(2, 1'b1, 5'd3, 32'hA000_0002);
      for (int i = 0; i < 3; i++) begin
         #1;
`ifdef WB_ARB_ROUND_ROBIN_EN
         expGrant = 3'b001 << i;
         expAddr  = 5'(i);
`else
         expGrant = 3'b001;
         expAddr  = (i == 0) ? 5'd0 : 5'd1;
`endif
         checkCount++;
         if (req_ready_o !== expGrant) $display("[TB] FAIL contention_grant%0d: got %b required %b", i, req_ready_o, expGrant);
         else passCount++;
         checkCount++;
         if (conflict_cnt_o !== 16'(i)) $display("[TB] FAIL contention_cnt%0d: got %0d required %0d", i, conflict_cnt_o, i);
         else passCount++;
         checkCount++;
         if ((i == 0 && rf_write_en_o !== 1'b0) ||
             (i != 0 && {rf_write_en_o, rf_rd_addr_o} !== {1'b1, expAddr}))
            $display("[TB] FAIL contention_write%0d: got en=%b addr=%0d required en=%b addr=%0d",
                     i, rf_write_en_o, rf_rd_addr_o, (i != 0), expAddr);
         else passCount++;
         nextCycle();
      end
      flush_i = 1'b1;
      #1;
`ifdef WB_ARB_ROUND_ROBIN_EN
      expAddr = 5'd3;
`else
      expAddr = 5'd1;
`endif
      checkCount++;
      if (req_ready_o !== 3'b000) $display("[TB] FAIL contention_flush_ready: got %b required 000", req_ready_o);
      else passCount++;
      checkCount++;
      if ({rf_write_en_o, rf_rd_addr_o} !== {1'b1, expAddr})
         $display("[TB] FAIL contention_last_write: got en=%b addr=%0d required en=1 addr=%0d", rf_write_en_o, rf_rd_addr_o, expAddr);
      else passCount++;
      nextCycle();
      flush_i = 1'b0;
      idleAll();
      #1;
      checkCount++;
      if (rf_write_en_o !== 1'b0) $display("[TB] FAIL contention_after_flush_wen: got %b required 0", rf_write_en_o);
      else passCount++;
      checkCount++;
      if (conflict_cnt_o !== 16'd3) $display("[TB] FAIL contention_flush_not_counted: got %0d required 3", conflict_cnt_o);
      else passCount++;
      nextCycle();
   endtask

   // Write to x0 is accepted but never reaches the register file.
   task automatic test_x0();
      applyStimulus(0, 1'b1, 5'd0, 32'h0000_1234);
      #1;
      checkCount++;
      if (req_ready_o !== 3'b001) $display("[TB] FAIL x0_ready: got %b required 001", req_ready_o);
      else passCount++;
      nextCycle();
      idleAll();
      for (int c = 0; c < 2; c++) begin
         #1;
         checkCount++;
         if (rf_write_en_o !== 1'b0) $display("[TB] FAIL x0_wen%0d: got %b required 0", c, rf_write_en_o);
         else passCount++;
         nextCycle();
      end
   endtask

   // Flush after a transfer, and flush in the same cycle as a request.
   task automatic test_flush();
      applyStimulus(2, 1'b1, 5'd7, 32'h0000_0077);
      #1;
      checkCount++;
      if (req_ready_o !== 3'b100) $display("[TB] FAIL flush_pre_ready: got %b required 100", req_ready_o);
      else passCount++;
      nextCycle();
      idleAll();
      flush_i = 1'b1;
      applyStimulus(0, 1'b1, 5'd9, 32'h0000_0099);
      #1;
      checkCount++;
      if (req_ready_o !== 3'b000) $display("[TB] FAIL flush_blocks_grant: got %b required 000", req_ready_o);
      else passCount++;
      checkCount++;
      if ({rf_write_en_o, rf_rd_addr_o, rf_rd_data_o} !== {1'b1, 5'd7, 32'h0000_0077})
         $display("[TB] FAIL flush_prior_write: got en=%b addr=%0d data=%h required en=1 addr=7 data=00000077",
                  rf_write_en_o, rf_rd_addr_o, rf_rd_data_o);
      else passCount++;
      nextCycle();
      flush_i = 1'b0;
      idleAll();
      #1;
      checkCount++;
      if (rf_write_en_o !== 1'b0) $display("[TB] FAIL flush_next_wen: got %b required 0", rf_write_en_o);
      else passCount++;
      nextCycle();
      flush_i = 1'b1;
      applyStimulus(2, 1'b1, 5'd8, 32'h0000_0088);
      #1;
      checkCount++;
      if (req_ready_o !== 3'b000) $display("[TB] FAIL flush_same_ready: got %b required 000", req_ready_o);
      else passCount++;
      nextCycle();
      flush_i = 1'b0;
      idleAll();
      #1;
      checkCount++;
      if ({rf_write_en_o, rf_rd_addr_o} !== {1'b0, 5'd7})
         $display("[TB] FAIL flush_same_write: got en=%b addr=%0d required en=0 addr=7", rf_write_en_o, rf_rd_addr_o);
      else passCount++;
      nextCycle();
   endtask

   // Different requesters on consecutive cycles: no bubble between writes.
   task automatic test_back_to_back();
      applyStimulus(0, 1'b1, 5'd10, 32'h0000_0001);
      nextCycle();
      idleAll();
      applyStimulus(1, 1'b1, 5'd11, 32'h0000_0002);
      #1;
      checkCount++;
      if (req_ready_o !== 3'b010) $display("[TB] FAIL b2b_ready: got %b required 010", req_ready_o);
      else passCount++;
      checkCount++;
      if ({rf_write_en_o, rf_rd_addr_o, rf_rd_data_o} !== {1'b1, 5'd10, 32'h0000_0001})
         $display("[TB] FAIL b2b_write0: got en=%b addr=%0d data=%h required en=1 addr=10 data=00000001",
                  rf_write_en_o, rf_rd_addr_o, rf_rd_data_o);
      else passCount++;
      nextCycle();
      idleAll();
      #1;
      checkCount++;
      if ({rf_write_en_o, rf_rd_addr_o, rf_rd_data_o} !== {1'b1, 5'd11, 32'h0000_0002})
         $display("[TB] FAIL b2b_write1: got en=%b addr=%0d data=%h required en=1 addr=11 data=00000002",
                  rf_write_en_o, rf_rd_addr_o, rf_rd_data_o);
      else passCount++;
      nextCycle();
      checkCount++;
      if (rf_write_en_o !== 1'b0) $display("[TB] FAIL b2b_idle: got %b required 0", rf_write_en_o);
      else passCount++;
   endtask

   // Drive 0x10005 contended cycles and watch the counter saturate.
   task automatic test_saturation();
      doReset();
      applyStimulus(0, 1'b1, 5'd1, 32'hC000_0000);
      applyStimulus(1, 1'b1, 5'd2, 32'hC000_0001);
      applyStimulus(2, 1'b1, 5'd3, 32'hC000_0002);
      for (int i = 0; i < 32'hFFFE; i++) nextCycle();
      checkCount++;
      if (conflict_cnt_o !== 16'hFFFE) $display("[TB] FAIL sat_before: got %h required fffe", conflict_cnt_o);
      else passCount++;
      nextCycle();
      checkCount++;
      if (conflict_cnt_o !== 16'hFFFF) $display("[TB] FAIL sat_reach: got %h required ffff", conflict_cnt_o);
      else passCount++;
      for (int i = 0; i < 6; i++) nextCycle();
      checkCount++;
      if (conflict_cnt_o !== 16'hFFFF) $display("[TB] FAIL sat_hold: got %h required ffff", conflict_cnt_o);
      else passCount++;
      flush_i = 1'b1;
      nextCycle();
      flush_i = 1'b0;
      idleAll();
      nextCycle();
   endtask

   initial begin
      rst_i   = 1'b1;
      flush_i = 1'b0;
      idleAll();
      test_reset();
      test_single();
      test_contention();
      test_x0();
      test_flush();
      test_back_to_back();
      test_saturation();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   // Absolute time limit so the run always ends on its own.
   initial begin
      #2_000_000;
      $display("[TB] FAIL timeout: simulation time limit reached, required completion");
      $fatal(1, "[TB] timeout");
   end

endmodule : tb_wb_port_arbiter
